// File: rtl/enc_pkg.sv
// Shared types and constants for the serial 4-to-2 encoder.
package enc_pkg;

  localparam int N = 4;
  localparam int W = 2;

  typedef enum logic {
    IDLE,
    SERVE
  } state_e;

  function automatic logic popcount_gt1(input logic [0:N-1] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + int'(v[i]);
    end
    return (cnt > 1);
  endfunction

endpackage

// File: rtl/prio_enc4.sv
// Combinational lowest-index finder: idx is the smallest i with vec[i] set.
module prio_enc4
  import enc_pkg::*;
(
  input  logic [0:N-1]  vec,
  output logic [W-1:0]  idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    any = |vec;
    // Scan downward so the lowest set index wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/enc4to2_serial.sv
// Captures a request vector and replays its set bits as a code stream over valid/ready.
module enc4to2_serial
  import enc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          En,
  input  logic [0:N-1]  D,
  input  logic          ready,
  output logic [W-1:0]  S,
  output logic          valid,
  output logic          busy,
  output logic          multi,
  output logic          done
);

  state_e         state_q, state_d;
  logic [0:N-1]   pending_q, pending_d;
  logic [W-1:0]   s_q, s_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           multi_q, multi_d;
  logic           done_q, done_d;

  logic [0:N-1]   pend_clr;
  logic [0:N-1]   vec;
  logic [W-1:0]   idx;
  logic           any;

  // One finder serves both the first code (from D) and every following code.
  prio_enc4 u_prio (
    .vec (vec),
    .idx (idx),
    .any (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      s_q       <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      multi_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      s_q       <= s_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      multi_q   <= multi_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    pend_clr      = pending_q;
    pend_clr[s_q] = 1'b0;
    vec           = (state_q == IDLE) ? D : pend_clr;

    state_d   = state_q;
    pending_d = pending_q;
    s_d       = s_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    multi_d   = multi_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (En && any) begin
          pending_d = D;
          state_d   = SERVE;
          s_d       = idx;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          multi_d   = popcount_gt1(D);
        end
      end
      SERVE: begin
        // valid is always high here, so ready alone completes a handshake.
        if (ready) begin
          pending_d = pend_clr;
          if (any) begin
            s_d = idx;
          end else begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign S     = s_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign multi = multi_q;
  assign done  = done_q;

endmodule
